time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  Sequences user time-setting from classified button events (short/long press pulses, 1 clk wide).
//  Holds shadow hour/min/sec edit registers, walks the edit field on mode presses, increments on inc presses.
//  Sits between the press classifiers and the timekeeping counter; commits edited time with a 1-cycle load pulse.
// PARAMETERS
//  TIMEOUT_TICKS  300000  idle clk_10000Hz cycles in a SET state before abandoning edit (30 s)
//  BLINK_HALF     2500    half-period of field blink in clk cycles (0.25 s); used only with TSC_BLINK_EN
// PORTS
//  clk_10000Hz  in   1  system tick clock, 10 kHz
//  rst          in   1  synchronous, active-high reset
//  mode_short   in   1  short-press pulse, mode button
//  mode_long    in   1  long-press pulse, mode button
//  inc_short    in   1  short-press pulse, inc button
//  inc_long     in   1  long-press pulse, inc button
//  cur_hour     in   5  live hour from timekeeper (0-23)
//  cur_min      in   6  live minute (0-59)
//  cur_sec      in   6  live second (0-59)
//  set_hour     out  5  edited hour
//  set_min      out  6  edited minute
//  set_sec      out  6  edited second
//  field_sel    out  2  0=none(RUN) 1=hour 2=min 3=sec
//  editing      out  1  1 in any SET state
//  load         out  1  1-cycle commit pulse; timekeeper loads set_* on it
//  blank        out  1  blank selected field digits (TSC_BLINK_EN only; else tied 0)
// BEHAVIOUR
//  Reset: state=RUN; set_*=0; field_sel=0; editing=0; load=0; blank=0; idle counter=0.
//  States: RUN, SET_H, SET_M, SET_S. All outputs registered; event at edge n visible at n+1.
//  Event priority same cycle: mode_long > mode_short > inc_long > inc_short; lower ones dropped.
//  RUN: mode_long -> SET_H, capture cur_* into set_*. All other events ignored.
//  SET_x: mode_short -> next field H->M->S->H (wrap). mode_long -> RUN, load=1 for exactly one cycle,
//   set_* hold their values (not cleared) so load samples stable data.
//  SET_x: inc_short -> field +1; inc_long -> field +10; both modulo limit (hour 24, min/sec 60).
//   Arithmetic 7-bit intermediate, single conditional subtract: 23+1=0, 19+10=5, 59+1=0, 55+10=5.
//  Idle counter: clears on any accepted event or state change, else increments in SET_x.
//   Reaching TIMEOUT_TICKS-1 -> RUN, load stays 0 (edit discarded), counter cleared. Held at 0 in RUN.
//  field_sel/editing follow state: RUN=0/0, SET_H=1/1, SET_M=2/1, SET_S=3/1.
//  rst mid-edit: immediate return to reset values next edge, no load pulse.
//  Simultaneous mode_long and timeout expiry: mode_long wins (commit).
// CONFIGURATION
//  TSC_BLINK_EN defined: blink counter runs in SET_x, blank toggles every BLINK_HALF cycles;
//   counter and blank reset to 0 on any accepted event (field visible right after press) and in RUN.
//  TSC_BLINK_EN undefined: no blink counter; blank constant 0; BLINK_HALF unused.
// TESTING (use TIMEOUT_TICKS=20, BLINK_HALF=4 in bench)
//  1. rst 1 cycle -> all outputs 0; cur=12:34:56, mode_long -> next cycle SET_H, set=12:34:56, field_sel=1.
//  2. In SET_H hour=23: inc_short -> 0; hour=19 inc_long -> 5; mode_short x3 -> field_sel 2,3,1.
//  3. SET_M min=55: inc_long -> 5; mode_long -> load=1 one cycle, set=..:05:.., state RUN, field_sel=0.
//  4. Enter SET, no events 20 cycles -> RUN, load never asserted; mode_long on expiry cycle -> load=1.
//  5. Same cycle mode_short+inc_short in SET_H -> field_sel=2, hour unchanged; rst mid-edit -> RUN, load=0.
//  6. TSC_BLINK_EN: in SET, blank toggles every 4 cycles; inc_short -> blank=0 next cycle, period restarts.

Source files
------------

// File: rtl/time_set_ctrl_if.sv
// Button-event, live-time and edited-time signals between the press classifiers,
// the time-setting sequencer and the timekeeper.
interface time_set_ctrl_if;
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MS_W   = 6;

    logic              mode_short;
    logic              mode_long;
    logic              inc_short;
    logic              inc_long;
    logic [HOUR_W-1:0] cur_hour;
    logic [MS_W-1:0]   cur_min;
    logic [MS_W-1:0]   cur_sec;
    logic [HOUR_W-1:0] set_hour;
    logic [MS_W-1:0]   set_min;
    logic [MS_W-1:0]   set_sec;
    logic [1:0]        field_sel;
    logic              editing;
    logic              load;
    logic              blank;

    modport master (
        output mode_short, mode_long, inc_short, inc_long,
        output cur_hour, cur_min, cur_sec,
        input  set_hour, set_min, set_sec, field_sel, editing, load, blank
    );

    modport slave (
        input  mode_short, mode_long, inc_short, inc_long,
        input  cur_hour, cur_min, cur_sec,
        output set_hour, set_min, set_sec, field_sel, editing, load, blank
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting sequencer: walks hour/min/sec edit fields from button events and commits
// with a one-cycle load pulse. Optional field blinking is enabled by defining TSC_BLINK_EN.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 300000,
    parameter int unsigned BLINK_HALF    = 2500
) (
    input  logic           clk_10000Hz,
    input  logic           rst,
    time_set_ctrl_if.slave bus
);
    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MS_W   = 6;
    localparam int unsigned IDLE_W = (TIMEOUT_TICKS > 2) ? $clog2(TIMEOUT_TICKS) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              timeout_c;

    // Add 1 or 10 with a single conditional wrap; inputs never exceed 59.
    function automatic logic [6:0] wrap_add(input logic [6:0] val, input logic big,
                                            input logic [6:0] limit);
        logic [6:0] sum;
        sum = val + (big ? 7'd10 : 7'd1);
        if (sum >= limit) begin
            sum = sum - limit;
        end
        return sum;
    endfunction

    assign timeout_c     = (state != RUN) && (idle_cnt == IDLE_LAST);
    assign bus.field_sel = state;

    always_ff @(posedge clk_10000Hz) begin
        if (rst) begin
            state        <= RUN;
            idle_cnt     <= '0;
            bus.set_hour <= '0;
            bus.set_min  <= '0;
            bus.set_sec  <= '0;
            bus.editing  <= 1'b0;
            bus.load     <= 1'b0;
        end else begin
            bus.load <= 1'b0;
            if (state == RUN) begin
                idle_cnt <= '0;
                if (bus.mode_long) begin
                    state        <= SET_H;
                    bus.editing  <= 1'b1;
                    bus.set_hour <= bus.cur_hour;
                    bus.set_min  <= bus.cur_min;
                    bus.set_sec  <= bus.cur_sec;
                end
            end else if (bus.mode_long) begin
                // Commit wins over a same-cycle timeout; set_* hold for the load sample.
                state       <= RUN;
                bus.editing <= 1'b0;
                bus.load    <= 1'b1;
                idle_cnt    <= '0;
            end else if (bus.mode_short) begin
                idle_cnt <= '0;
                case (state)
                    SET_H:   state <= SET_M;
                    SET_M:   state <= SET_S;
                    default: state <= SET_H;
                endcase
            end else if (bus.inc_long || bus.inc_short) begin
                idle_cnt <= '0;
                case (state)
                    SET_H:   bus.set_hour <= HOUR_W'(wrap_add(7'(bus.set_hour), bus.inc_long, 7'd24));
                    SET_M:   bus.set_min  <= MS_W'(wrap_add(7'(bus.set_min), bus.inc_long, 7'd60));
                    default: bus.set_sec  <= MS_W'(wrap_add(7'(bus.set_sec), bus.inc_long, 7'd60));
                endcase
            end else if (timeout_c) begin
                state       <= RUN;
                bus.editing <= 1'b0;
                idle_cnt    <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

`ifdef TSC_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               ev_accept_c;

    assign ev_accept_c = bus.mode_long ||
                         ((state != RUN) && (bus.mode_short || bus.inc_long || bus.inc_short));

    // Restart the blink phase with the field visible after every accepted press.
    always_ff @(posedge clk_10000Hz) begin
        if (rst || (state == RUN) || ev_accept_c || timeout_c) begin
            blink_cnt <= '0;
            bus.blank <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            bus.blank <= ~bus.blank;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_blink_c;
    assign unused_blink_c = |BLINK_HALF;
    assign bus.blank      = 1'b0;
`endif
endmodule
